// File: rtl/motor_drive.sv
// Dual H-bridge motor driver: 15-slot PWM, ramped duty changes and a
// bridge-off dead time on direction change or emergency stop.
module motor_drive #(
   parameter int unsigned clk_f    = 50_000_000,
   parameter int unsigned cmd_l    = 4,
   parameter int unsigned slot_div = clk_f / (15 * 20_000),
   parameter int unsigned ramp_div = clk_f / 100,
   parameter int unsigned dead_cyc = clk_f / 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [cmd_l-1:0] speed_cmd,
   input  logic [cmd_l-1:0] dir_cmd,
   input  logic             estop,
   output logic             la,
   output logic             lb,
   output logic             ra,
   output logic             rb,
   output logic [cmd_l-1:0] duty_o,
   output logic [1:0]       state_o
);

   localparam int unsigned PW = (slot_div > 1) ? $clog2(slot_div) : 1;
   localparam int unsigned RW = (ramp_div > 1) ? $clog2(ramp_div) : 1;
   localparam int unsigned DW = (dead_cyc > 0) ? $clog2(dead_cyc + 1) : 1;

   localparam logic [cmd_l-1:0] C_FWD   = cmd_l'(4'b1000);
   localparam logic [cmd_l-1:0] C_REV   = cmd_l'(4'b0100);
   localparam logic [cmd_l-1:0] C_LEFT  = cmd_l'(4'b0010);
   localparam logic [cmd_l-1:0] C_RIGHT = cmd_l'(4'b0001);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RAMP_DOWN = 2'd2, DEAD = 2'd3} state_t;
   typedef enum logic [2:0] {D_STOP, D_FWD, D_REV, D_LEFT, D_RIGHT} dir_t;

   state_t           state_q, state_n;
   dir_t             cur_dir_q, cur_dir_n, tgt;
   logic [PW-1:0]    pre_q;
   logic [cmd_l-1:0] slot_q;
   logic [RW-1:0]    rcnt_q;
   logic [DW-1:0]    dead_q, dead_n;
   logic [cmd_l-1:0] duty_n, duty_pwm_q, duty_pwm_n;
   logic [3:0]       bridge_n;
   logic             pre_tc, slot_wrap, tick, p, go;

   assign pre_tc    = (pre_q == PW'(slot_div - 1));
   assign slot_wrap = pre_tc && (slot_q == cmd_l'(14));
   assign tick      = (rcnt_q == RW'(ramp_div - 1));
   assign p         = (slot_q < duty_pwm_q);
   assign state_o   = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         slot_q <= '0;
         rcnt_q <= '0;
      end else begin
         pre_q  <= pre_tc ? '0 : pre_q + 1'b1;
         if (pre_tc) slot_q <= slot_wrap ? '0 : slot_q + 1'b1;
         rcnt_q <= tick ? '0 : rcnt_q + 1'b1;
      end
   end

   always_comb begin
      tgt = D_STOP;
      case (dir_cmd)
         C_FWD:   tgt = D_FWD;
         C_REV:   tgt = D_REV;
         C_LEFT:  tgt = D_LEFT;
         C_RIGHT: tgt = D_RIGHT;
         default: tgt = D_STOP;
      endcase
   end

   assign go = (tgt != D_STOP) && (speed_cmd != '0);

   always_comb begin
      state_n    = state_q;
      cur_dir_n  = cur_dir_q;
      duty_n     = duty_o;
      dead_n     = dead_q;
      duty_pwm_n = slot_wrap ? duty_o : duty_pwm_q;
      if (estop) begin
         state_n    = DEAD;
         duty_n     = '0;
         duty_pwm_n = '0;
         dead_n     = DW'(dead_cyc);
      end else begin
         case (state_q)
            IDLE: begin
               duty_n = '0;
               if (go) begin
                  cur_dir_n = tgt;
                  state_n   = RUN;
               end
            end
            RUN: begin
               if (duty_o == '0 && speed_cmd == '0) begin
                  state_n   = IDLE;
                  cur_dir_n = D_STOP;
               end else if (tgt != cur_dir_q) begin
                  state_n = RAMP_DOWN;
               end else if (tick) begin
                  if (duty_o < speed_cmd)      duty_n = duty_o + 1'b1;
                  else if (duty_o > speed_cmd) duty_n = duty_o - 1'b1;
               end
            end
            RAMP_DOWN: begin
               if (duty_o == '0) begin
                  state_n = DEAD;
                  dead_n  = DW'(dead_cyc);
               end else if (tick) begin
                  duty_n = duty_o - 1'b1;
                  if (duty_o == cmd_l'(1)) begin
                     state_n = DEAD;
                     dead_n  = DW'(dead_cyc);
                  end
               end
            end
            DEAD: begin
               // Stale PWM duty must not reach the bridge in the new direction.
               duty_pwm_n = '0;
               if (dead_q > DW'(1)) begin
                  dead_n = dead_q - 1'b1;
               end else begin
                  dead_n = '0;
                  if (go) begin
                     cur_dir_n = tgt;
                     state_n   = RUN;
                  end else begin
                     cur_dir_n = D_STOP;
                     state_n   = IDLE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Legs follow the next state so they are registered alongside state_o.
   always_comb begin
      bridge_n = '0;
      if (!estop && (state_n == RUN || state_n == RAMP_DOWN)) begin
         case (cur_dir_n)
            D_FWD:   bridge_n = {p, 1'b0, p, 1'b0};
            D_REV:   bridge_n = {1'b0, p, 1'b0, p};
            D_LEFT:  bridge_n = {1'b0, p, p, 1'b0};
            D_RIGHT: bridge_n = {p, 1'b0, 1'b0, p};
            default: bridge_n = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cur_dir_q       <= D_STOP;
         duty_o          <= '0;
         duty_pwm_q      <= '0;
         dead_q          <= '0;
         {la, lb, ra, rb} <= '0;
      end else begin
         state_q         <= state_n;
         cur_dir_q       <= cur_dir_n;
         duty_o          <= duty_n;
         duty_pwm_q      <= duty_pwm_n;
         dead_q          <= dead_n;
         {la, lb, ra, rb} <= bridge_n;
      end
   end

endmodule
